// File: rtl/mesh_router_vc.sv
// 5-port (L,N,S,E,W) wormhole mesh router: per-input FIFOs, XY routing, credit flow control,
// round-robin switch allocation with packet locking, and a sticky error flag.
module mesh_router_vc #(
  parameter int FLIT_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]          in_valid,
  output logic [4:0]          credit_out,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]          out_valid,
  input  logic [4:0]          credit_in,
  output logic                err
);

  localparam int NP    = 5;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] MY_XA   = ADDR_W'(MY_X);
  localparam logic [ADDR_W-1:0] MY_YA   = ADDR_W'(MY_Y);

  typedef enum logic [2:0] {PORT_L, PORT_N, PORT_S, PORT_E, PORT_W} port_e;
  typedef enum logic [1:0] {FT_SINGLE, FT_HEAD, FT_BODY, FT_TAIL} flitType_e;

  logic [FLIT_W-1:0] mem [NP][BUF_DEPTH];
  logic [PTR_W-1:0]  rdPtr [NP];
  logic [PTR_W-1:0]  wrPtr [NP];
  logic [CNT_W-1:0]  fill [NP];
  port_e             heldRoute [NP];
  logic [CNT_W-1:0]  credit [NP];
  logic [NP-1:0]     locked;
  logic [2:0]        lockOwner [NP];
  logic [2:0]        rrPtr [NP];

  logic [FLIT_W-1:0] headFlit [NP];
  port_e             curRoute [NP];
  logic [NP-1:0]     notEmpty, full, wrOk, isHead, isTail, uTurn, deq, send;
  logic [2:0]        sendSrc [NP];

  function automatic port_e xyRoute(input logic [FLIT_W-1:0] f);
    logic [ADDR_W-1:0] dx, dy;
    dx = f[FLIT_W-9 -: ADDR_W];
    dy = f[FLIT_W-9-ADDR_W -: ADDR_W];
    if (dx > MY_XA)      return PORT_E;
    else if (dx < MY_XA) return PORT_W;
    else if (dy > MY_YA) return PORT_N;
    else if (dy < MY_YA) return PORT_S;
    else                 return PORT_L;
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      headFlit[i] = mem[i][rdPtr[i]];
      notEmpty[i] = (fill[i] != '0);
      full[i]     = (fill[i] == DEPTH_C);
      wrOk[i]     = in_valid[i] && !full[i];
      isHead[i]   = (headFlit[i][FLIT_W-1 -: 2] == FT_SINGLE) || (headFlit[i][FLIT_W-1 -: 2] == FT_HEAD);
      isTail[i]   = (headFlit[i][FLIT_W-1 -: 2] == FT_SINGLE) || (headFlit[i][FLIT_W-1 -: 2] == FT_TAIL);
      // body/tail flits follow the route latched when their head left
      curRoute[i] = isHead[i] ? xyRoute(headFlit[i]) : heldRoute[i];
      uTurn[i]    = notEmpty[i] && (curRoute[i] == 3'(i));
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NP; o++) begin
      logic            found;
      logic [2:0]      src;
      int unsigned     idx;
      found = 1'b0;
      src   = '0;
      idx   = 0;
      if (locked[o]) begin
        if (notEmpty[lockOwner[o]] && (curRoute[lockOwner[o]] == 3'(o))) begin
          found = 1'b1;
          src   = lockOwner[o];
        end
      end else begin
        for (int unsigned k = 0; k < NP; k++) begin
          idx = (32'(rrPtr[o]) + k) % NP;
          if (!found && notEmpty[idx] && isHead[idx] && !uTurn[idx] && (curRoute[idx] == 3'(o))) begin
            found = 1'b1;
            src   = 3'(idx);
          end
        end
      end
      send[o]    = found && (credit[o] != '0);
      sendSrc[o] = src;
    end
    deq = uTurn;
    for (int unsigned o = 0; o < NP; o++)
      if (send[o]) deq[sendSrc[o]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NP; i++) begin
        rdPtr[i]     <= '0;
        wrPtr[i]     <= '0;
        fill[i]      <= '0;
        heldRoute[i] <= PORT_L;
        credit[i]    <= DEPTH_C;
        lockOwner[i] <= '0;
        rrPtr[i]     <= '0;
      end
      locked     <= '0;
      out_flit   <= '0;
      out_valid  <= '0;
      credit_out <= '0;
      err        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (wrOk[i]) begin
          mem[i][wrPtr[i]] <= in_flit[i*FLIT_W +: FLIT_W];
          wrPtr[i]         <= nextPtr(wrPtr[i]);
        end
        if (deq[i]) rdPtr[i] <= nextPtr(rdPtr[i]);
        fill[i] <= fill[i] + CNT_W'(wrOk[i]) - CNT_W'(deq[i]);
        if (deq[i] && isHead[i]) heldRoute[i] <= curRoute[i];
      end

      // a full FIFO always overflows, even if it is read on the same edge
      if ((|(in_valid & full)) || (|uTurn)) err <= 1'b1;
      credit_out <= deq;

      for (int unsigned o = 0; o < NP; o++) begin
        out_valid[o] <= send[o];
        if (send[o]) begin
          out_flit[o*FLIT_W +: FLIT_W] <= headFlit[sendSrc[o]];
          if (!locked[o]) rrPtr[o] <= (sendSrc[o] == 3'd4) ? 3'd0 : sendSrc[o] + 3'd1;
          if (isTail[sendSrc[o]]) begin
            locked[o] <= 1'b0;
          end else if (isHead[sendSrc[o]]) begin
            locked[o]    <= 1'b1;
            lockOwner[o] <= sendSrc[o];
          end
        end
        case ({send[o], credit_in[o]})
          2'b10:   credit[o] <= credit[o] - CNT_W'(1);
          2'b01:   if (credit[o] < DEPTH_C) credit[o] <= credit[o] + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
